// File: rtl/micro_if_pkg.sv
// Shared FSM states and command codes for the microcontroller register interface.
package micro_if_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ADDR_SET = 2'd1,
      CLEARING = 2'd2
   } state_t;

   localparam logic [7:0] CMD_CLEAR_ERR = 8'h80;
   localparam logic [7:0] CMD_CLEAR_ALL = 8'h81;
   localparam int         CMD_BIT       = 7;

endpackage

// File: rtl/micro_input_sync.sv
// Synchronises the micro byte, rsel and write strobe through one shared chain and
// emits a one-cycle accept on the strobe's rising edge, registered with its byte.
module micro_input_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] pin_data,
   input  logic       pin_rsel,
   input  logic       pin_write,
   output logic [7:0] data,
   output logic       rsel,
   output logic       accept
);

   // {write, rsel, data} travel together so the byte stays aligned with its strobe
   logic [9:0] chain [SYNC_STAGES];
   logic       write_seen;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
         write_seen <= 1'b0;
         data       <= '0;
         rsel       <= 1'b0;
         accept     <= 1'b0;
      end else begin
         chain[0] <= {pin_write, pin_rsel, pin_data};
         for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
         write_seen <= chain[SYNC_STAGES-1][9];
         accept     <= chain[SYNC_STAGES-1][9] & ~write_seen;
         data       <= chain[SYNC_STAGES-1][7:0];
         rsel       <= chain[SYNC_STAGES-1][8];
      end
   end

endmodule

// File: rtl/micro_reg_interface.sv
// Micro-port register bank with auto-increment, commands and a clear-all sweep; pin-to-write
// latency SYNC_STAGES+2. Define MICRO_REG_SHADOW_EN to expose the bank only at frame_start.
module micro_reg_interface
   import micro_if_pkg::*;
#(
   parameter int NUM_REGS    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic [7:0]                  fpga_port_in,
   input  logic                        fpga_rsel,
   input  logic                        fpga_write,
   input  logic                        frame_start,
   output logic [8*NUM_REGS-1:0]       regs_out,
   output logic                        wr_pulse,
   output logic [$clog2(NUM_REGS)-1:0] wr_addr,
   output logic                        busy,
   output logic                        err
);

   localparam int         AW         = $clog2(NUM_REGS);
   localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

   logic [7:0]    data;
   logic          rsel;
   logic          accept;
   state_t        state;
   logic [AW-1:0] addr_ptr;
   logic [AW-1:0] clr_idx;
   logic [7:0]    bank [NUM_REGS];

   micro_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .Clk       (Clk),
      .Reset     (Reset),
      .pin_data  (fpga_port_in),
      .pin_rsel  (fpga_rsel),
      .pin_write (fpga_write),
      .data      (data),
      .rsel      (rsel),
      .accept    (accept)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         addr_ptr <= '0;
         clr_idx  <= '0;
         wr_addr  <= '0;
         wr_pulse <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
      end else begin
         wr_pulse <= 1'b0;
         case (state)
            CLEARING: begin
               bank[clr_idx] <= '0;
               clr_idx       <= clr_idx + 1'b1;
               if (clr_idx == AW'(NUM_REGS - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               if (accept) err <= 1'b1;
            end
            default: begin
               if (accept) begin
                  if (!rsel) begin
                     if (data[CMD_BIT]) begin
                        if (data == CMD_CLEAR_ERR) begin
                           err <= 1'b0;
                        end else if (data == CMD_CLEAR_ALL) begin
                           state   <= CLEARING;
                           busy    <= 1'b1;
                           clr_idx <= '0;
                        end else begin
                           err <= 1'b1;
                        end
                     end else if (data < NUM_REGS_B) begin
                        addr_ptr <= data[AW-1:0];
                        state    <= ADDR_SET;
                     end else begin
                        err   <= 1'b1;
                        state <= IDLE;
                     end
                  end else if (state == ADDR_SET) begin
                     // power-of-two bank, so the pointer wraps naturally
                     bank[addr_ptr] <= data;
                     wr_pulse       <= 1'b1;
                     wr_addr        <= addr_ptr;
                     addr_ptr       <= addr_ptr + 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

`ifdef MICRO_REG_SHADOW_EN
   logic [7:0] shadow [NUM_REGS];

   // copies pre-write values when a write coincides with frame_start
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      end else if (frame_start) begin
         for (int i = 0; i < NUM_REGS; i++) shadow[i] <= bank[i];
      end
   end

   always_comb begin
      regs_out = '0;
      for (int i = 0; i < NUM_REGS; i++) regs_out[8*i +: 8] = shadow[i];
   end
`else
   logic unused_frame_start;
   assign unused_frame_start = frame_start;

   always_comb begin
      regs_out = '0;
      for (int i = 0; i < NUM_REGS; i++) regs_out[8*i +: 8] = bank[i];
   end
`endif

endmodule
